// File: rtl/noc_trace_pkg.sv
// Shared types for the mesh-NoC trace path: sequencer states, entry payload and
// field widths, used by the trace generator, the injection sequencer and benches.
package noc_trace_pkg;

  localparam int unsigned NODE_W = 4;
  localparam int unsigned TS_W   = 32;
  localparam logic [TS_W-1:0] END_MARK = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_TIME,
    ST_INJECT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [NODE_W-1:0] src;
    logic [NODE_W-1:0] dest;
  } entry_t;

endpackage

// File: rtl/trace_inject_ctrl_if.sv
// Trace-fetch and packet-injection signals between the sequencer (master),
// the trace generator and the per-node injection ports (slave).
interface trace_inject_ctrl_if #(
  parameter int unsigned NODES = 16
);
  import noc_trace_pkg::*;

  logic [31:0]       trace_addr;
  logic [TS_W-1:0]   trace_cycle;
  logic [NODE_W-1:0] trace_src;
  logic [NODE_W-1:0] trace_dest;
  logic              inj_valid;
  logic [NODE_W-1:0] inj_src;
  logic [NODE_W-1:0] inj_dest;
  logic [NODES-1:0]  inj_ready;

  modport master (
    output trace_addr, inj_valid, inj_src, inj_dest,
    input  trace_cycle, trace_src, trace_dest, inj_ready
  );

  modport slave (
    input  trace_addr, inj_valid, inj_src, inj_dest,
    output trace_cycle, trace_src, trace_dest, inj_ready
  );

endinterface

// File: rtl/trace_stat_cnt.sv
// Saturating statistics counter: clr has priority, inc adds one until all-ones.
module trace_stat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/trace_inject_ctrl.sv
// Trace-driven injection sequencer: walks generator entries, holds each until the
// global cycle reaches its timestamp, then hands it to its source node's port.
module trace_inject_ctrl #(
  parameter int unsigned RD_LAT     = 2,
  parameter logic [31:0] FIRST_ADDR = 32'd1,
  parameter logic [31:0] LAST_ADDR  = 32'd65535,
  parameter logic [31:0] END_MARK   = noc_trace_pkg::END_MARK,
  parameter int unsigned NODES      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  trace_inject_ctrl_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [31:0]         sim_cycle,
  output logic [31:0]         pkt_count,
  output logic [31:0]         late_count
);
  import noc_trace_pkg::*;

  localparam int unsigned FCNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  entry_t              ent_q, ent_d;
  logic                inj_valid_q, inj_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start_acc, xfer, late_inc;
  logic [NODES-1:0]    ready;

  assign ready = bus.inj_ready;

  // Next-state, entry capture and counter strobes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    fcnt_d    = fcnt_q;
    ent_d     = ent_q;
    start_acc = 1'b0;
    xfer      = 1'b0;
    late_inc  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          addr_d    = FIRST_ADDR;
          fcnt_d    = FCNT_W'(RD_LAT);
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fcnt_q == '0) begin
          ent_d = '{ts: bus.trace_cycle, src: bus.trace_src, dest: bus.trace_dest};
          if (bus.trace_cycle == END_MARK) begin
            state_d = ST_DONE;
          end else if (bus.trace_cycle < sim_cycle) begin
            late_inc = 1'b1;
            state_d  = ST_INJECT;
          end else if (bus.trace_cycle == sim_cycle) begin
            state_d = ST_INJECT;
          end else begin
            state_d = ST_WAIT_TIME;
          end
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
      ST_WAIT_TIME: begin
        if (sim_cycle >= ent_q.ts) begin
          state_d = ST_INJECT;
        end
      end
      ST_INJECT: begin
        // Only the entry's own source node can accept it.
        if (ready[ent_q.src]) begin
          xfer = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + 32'd1;
            fcnt_d  = FCNT_W'(RD_LAT);
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inj_valid_d = (state_d == ST_INJECT);
    busy_d      = (state_d == ST_FETCH) || (state_d == ST_WAIT_TIME) || (state_d == ST_INJECT);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      fcnt_q      <= '0;
      ent_q       <= '0;
      inj_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fcnt_q      <= fcnt_d;
      ent_q       <= ent_d;
      inj_valid_q <= inj_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  trace_stat_cnt #(.W(32)) u_sim_cnt (
    .clk (clk), .rst (rst), .clr (start_acc), .inc (busy_q),   .cnt (sim_cycle)
  );
  trace_stat_cnt #(.W(32)) u_pkt_cnt (
    .clk (clk), .rst (rst), .clr (start_acc), .inc (xfer),     .cnt (pkt_count)
  );
  trace_stat_cnt #(.W(32)) u_late_cnt (
    .clk (clk), .rst (rst), .clr (start_acc), .inc (late_inc), .cnt (late_count)
  );

  assign bus.trace_addr = addr_q;
  assign bus.inj_valid  = inj_valid_q;
  assign bus.inj_src    = ent_q.src;
  assign bus.inj_dest   = ent_q.dest;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_trace_inject_ctrl.sv
// Directed bench for trace_inject_ctrl: a two-stage trace generator model per DUT
// and hand-computed injection times, counters and end states.
module tb_trace_inject_ctrl;
  import noc_trace_pkg::*;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        busy1, done1, busy2, done2;
  logic [31:0] sim1, pkt1, late1, sim2, pkt2, late2;
  int          n_checks = 0;
  int          n_err    = 0;

  entry_t mem [8];
  entry_t g1_s1, g1_s2, g2_s1, g2_s2;

  trace_inject_ctrl_if #(.NODES(16)) bus1 ();
  trace_inject_ctrl_if #(.NODES(16)) bus2 ();

  always #5 clk = ~clk;

  function automatic entry_t lookup(input logic [31:0] a);
    entry_t e;
    if (a == 32'd0) e = '0;
    else if (a > 32'd7) e = '{ts: END_MARK, src: 4'd0, dest: 4'd0};
    else e = mem[a[2:0]];
    return e;
  endfunction

  // Generator model: outputs follow an address change after two edges.
  always @(posedge clk) begin
    g1_s1 <= lookup(bus1.trace_addr);
    g1_s2 <= g1_s1;
    g2_s1 <= lookup(bus2.trace_addr);
    g2_s2 <= g2_s1;
  end

  assign bus1.trace_cycle = g1_s2.ts;
  assign bus1.trace_src   = g1_s2.src;
  assign bus1.trace_dest  = g1_s2.dest;
  assign bus2.trace_cycle = g2_s2.ts;
  assign bus2.trace_src   = g2_s2.src;
  assign bus2.trace_dest  = g2_s2.dest;

  trace_inject_ctrl dut (
    .clk (clk), .rst (rst), .start (start1), .bus (bus1),
    .busy (busy1), .done (done1), .sim_cycle (sim1),
    .pkt_count (pkt1), .late_count (late1)
  );

  trace_inject_ctrl #(.LAST_ADDR(32'd2)) dut2 (
    .clk (clk), .rst (rst), .start (start2), .bus (bus2),
    .busy (busy2), .done (done2), .sim_cycle (sim2),
    .pkt_count (pkt2), .late_count (late2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int sel, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      seen = (sel == 1) ? bus1.inj_valid : bus2.inj_valid;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int sel, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      seen = (sel == 1) ? done1 : done2;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic pulse_start1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  initial begin
    mem[0] = '0;
    mem[1] = '{ts: 32'd5, src: 4'd2, dest: 4'd7};
    mem[2] = '{ts: 32'd5, src: 4'd3, dest: 4'd8};
    mem[3] = '{ts: 32'd9, src: 4'd0, dest: 4'd15};
    for (int i = 4; i < 8; i++) mem[i] = '{ts: END_MARK, src: 4'd0, dest: 4'd0};
    bus1.inj_ready = 16'hFFFF;
    bus2.inj_ready = 16'hFFFF;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_addr",  bus1.trace_addr, 32'd0);
    chk("rst_valid", 32'(bus1.inj_valid), 32'd0);
    chk("rst_busy",  32'(busy1), 32'd0);
    chk("rst_done",  32'(done1), 32'd0);
    chk("rst_sim",   sim1, 32'd0);
    chk("rst_pkt",   pkt1, 32'd0);

    // Basic trace: first entry on time, later entries behind the read latency
    pulse_start1();
    chk("t1_start_addr", bus1.trace_addr, 32'd1);
    chk("t1_start_busy", 32'(busy1), 32'd1);
    chk("t1_start_sim",  sim1, 32'd0);
    wait_valid(1, "t1_inj1");
    chk("t1_inj1_sim",  sim1, 32'd6);
    chk("t1_inj1_src",  32'(bus1.inj_src), 32'd2);
    chk("t1_inj1_dest", 32'(bus1.inj_dest), 32'd7);
    chk("t1_inj1_late", late1, 32'd0);
    wait_valid(1, "t1_inj2");
    chk("t1_inj2_sim",  sim1, 32'd10);
    chk("t1_inj2_src",  32'(bus1.inj_src), 32'd3);
    chk("t1_inj2_dest", 32'(bus1.inj_dest), 32'd8);
    chk("t1_inj2_late", late1, 32'd1);
    wait_valid(1, "t1_inj3");
    chk("t1_inj3_sim",  sim1, 32'd14);
    chk("t1_inj3_src",  32'(bus1.inj_src), 32'd0);
    chk("t1_inj3_dest", 32'(bus1.inj_dest), 32'd15);
    wait_done(1, "t1_done");
    chk("t1_done_sim",  sim1, 32'd18);
    chk("t1_done_pkt",  pkt1, 32'd3);
    chk("t1_done_late", late1, 32'd2);
    chk("t1_done_addr", bus1.trace_addr, 32'd4);
    chk("t1_done_busy", 32'(busy1), 32'd0);
    tick();
    tick();
    chk("t1_hold_sim",  sim1, 32'd18);
    chk("t1_hold_done", 32'(done1), 32'd1);

    // Back-pressure on node 2 only; every other node ready
    bus1.inj_ready = 16'hFFFB;
    pulse_start1();
    chk("t2_start_pkt", pkt1, 32'd0);
    wait_valid(1, "t2_inj1");
    chk("t2_inj1_sim", sim1, 32'd6);
    for (int k = 7; k <= 20; k++) begin
      tick();
      chk("t2_hold_valid", 32'(bus1.inj_valid), 32'd1);
      chk("t2_hold_src",   32'(bus1.inj_src), 32'd2);
      chk("t2_hold_dest",  32'(bus1.inj_dest), 32'd7);
      chk("t2_hold_sim",   sim1, 32'(k));
    end
    chk("t2_hold_pkt", pkt1, 32'd0);
    bus1.inj_ready = 16'hFFFF;
    tick();
    chk("t2_xfer_valid", 32'(bus1.inj_valid), 32'd0);
    chk("t2_xfer_pkt",   pkt1, 32'd1);
    chk("t2_xfer_sim",   sim1, 32'd21);
    wait_valid(1, "t2_inj2");
    chk("t2_inj2_sim", sim1, 32'd24);
    chk("t2_inj2_src", 32'(bus1.inj_src), 32'd3);
    wait_done(1, "t2_done");
    chk("t2_done_sim",  sim1, 32'd32);
    chk("t2_done_pkt",  pkt1, 32'd3);
    chk("t2_done_late", late1, 32'd2);

    // Timestamp 0: late at capture
    mem[1] = '{ts: 32'd0, src: 4'd2, dest: 4'd7};
    pulse_start1();
    wait_valid(1, "t3_inj1");
    chk("t3_inj1_sim",  sim1, 32'd3);
    chk("t3_inj1_late", late1, 32'd1);
    wait_done(1, "t3_done");
    chk("t3_done_sim",  sim1, 32'd15);
    chk("t3_done_pkt",  pkt1, 32'd3);
    chk("t3_done_late", late1, 32'd3);
    mem[1] = '{ts: 32'd5, src: 4'd2, dest: 4'd7};

    // Start while busy is ignored
    pulse_start1();
    chk("t5_clr_pkt",  pkt1, 32'd0);
    chk("t5_clr_late", late1, 32'd0);
    tick();
    tick();
    tick();
    pulse_start1();
    chk("t5_busy_sim",  sim1, 32'd4);
    chk("t5_busy_addr", bus1.trace_addr, 32'd1);
    chk("t5_busy_busy", 32'(busy1), 32'd1);
    wait_valid(1, "t5_inj1");
    chk("t5_inj1_sim", sim1, 32'd6);

    // Reset while injecting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", 32'(bus1.inj_valid), 32'd0);
    chk("t5_rst_addr",  bus1.trace_addr, 32'd0);
    chk("t5_rst_busy",  32'(busy1), 32'd0);
    chk("t5_rst_sim",   sim1, 32'd0);
    tick();
    tick();
    chk("t5_idle_busy", 32'(busy1), 32'd0);
    chk("t5_idle_sim",  sim1, 32'd0);
    pulse_start1();
    chk("t5_re_addr", bus1.trace_addr, 32'd1);
    chk("t5_re_sim",  sim1, 32'd0);
    wait_valid(1, "t5_re_inj1");
    chk("t5_re_inj1_sim", sim1, 32'd6);
    chk("t5_re_inj1_src", 32'(bus1.inj_src), 32'd2);
    wait_done(1, "t5_re_done");
    chk("t5_re_done_sim", sim1, 32'd18);
    chk("t5_re_done_pkt", pkt1, 32'd3);

    // LAST_ADDR=2 stops after two entries without END_MARK
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_valid(2, "t4_inj1");
    chk("t4_inj1_sim", sim2, 32'd6);
    chk("t4_inj1_src", 32'(bus2.inj_src), 32'd2);
    wait_valid(2, "t4_inj2");
    chk("t4_inj2_sim", sim2, 32'd10);
    chk("t4_inj2_src", 32'(bus2.inj_src), 32'd3);
    wait_done(2, "t4_done");
    chk("t4_done_sim",  sim2, 32'd11);
    chk("t4_done_pkt",  pkt2, 32'd2);
    chk("t4_done_late", late2, 32'd1);
    chk("t4_done_addr", bus2.trace_addr, 32'd2);
    tick();
    tick();
    tick();
    chk("t4_hold_addr",  bus2.trace_addr, 32'd2);
    chk("t4_hold_valid", 32'(bus2.inj_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
